rr_encoder_arbiter: RTL and testbench
=====================================

// Module: rr_encoder_arbiter
//
// PURPOSE
//   Round-robin arbiter that shares one downstream consumer among N requesters.
//   Each cycle it selects one active request using rotating priority.
//   It presents the winner as a one-hot grant plus a binary index (the
//   16-to-4 encoding), held under a valid/ready handshake.
//   It sits in front of the binary-encoded select path and sequences which
//   requester the encoder output refers to.
//
// PARAMETERS
//   N  16           number of requesters (power of 2, >= 2)
//   W  $clog2(N)=4  width of the binary grant index; derived, not overridden
//
// PORTS
//   clk         input   1    clock, all logic on rising edge
//   rst         input   1    synchronous, active-high reset
//   enable      input   1    arbitration enable; low = no new grants issued
//   req         input   N    request vector, bit i = requester i
//   gnt_ready   input   1    downstream accepts the current grant
//   gnt_valid   output  1    grant outputs are valid
//   gnt_onehot  output  N    one-hot grant; all-zero when gnt_valid=0
//   gnt_idx     output  W    binary index of the granted bit; 0 when gnt_valid=0
//   busy        output  1    FSM in GRANT state (equals gnt_valid)
//
// BEHAVIOUR
// - Reset: state=IDLE, gnt_valid=0, gnt_onehot=0, gnt_idx=0, busy=0, ptr=0.
//   - rst has priority over every other input.
//   - Asserting rst mid-grant drops the pending grant at the next edge.
// - ptr (W bits, internal) is the highest-priority index.
//   - Search order: ptr, ptr+1, ... N-1, 0, ... ptr-1, mod N.
// - All outputs are registered.
//   - Latency is 1 cycle from a sampled req/enable to gnt_valid=1.
// - Invariants:
//   - gnt_onehot == (1 << gnt_idx) whenever gnt_valid=1.
//   - gnt_onehot has exactly one bit set when valid.
// - FSM states IDLE and GRANT.
//   - IDLE, enable=1 and |req:
//     - Register the winner into gnt_idx and gnt_onehot.
//     - Set gnt_valid=1 and go to GRANT.
//   - IDLE otherwise: stay; outputs remain zero.
//   - GRANT, gnt_ready=0: hold every output stable.
//     - Changes to req or enable are ignored.
//     - A dropped request is never retracted.
//   - GRANT, gnt_ready=1 (handshake):
//     - ptr <= gnt_idx+1 mod N; this wraps N-1 to 0.
//     - If enable=1 and |req: arbitrate the current req using the NEW ptr and
//       stay in GRANT. This allows back-to-back grants, one per cycle.
//     - Else: go to IDLE and clear the outputs.
//   - A requester granted last is lowest priority next.
//     - If it is the only requester, it is granted again.
// - enable falling during GRANT:
//   - The current grant completes normally.
//   - No further grant is issued.
// - ptr changes only on a handshake or on reset.
//   - It never changes while stalled or idle.
//
// TESTING
// 1. Single request: rst, then enable=1, req=16'h0002.
//    -> next cycle gnt_valid=1, gnt_idx=1, gnt_onehot=16'h0002.
// 2. Round-robin: req=16'hFFFF, gnt_ready=1 held high.
//    -> gnt_idx=0,1,2..15,0, one grant per cycle.
// 3. Stall: req=16'h0010, gnt_ready=0 for 5 cycles, req changed to 16'h8000.
//    -> gnt_idx=4 held for 5 cycles.
//    -> after gnt_ready=1, gnt_idx=15 on the next cycle.
// 4. Sole requester: req=16'h0001, gnt_ready=1.
//    -> gnt_idx=0 every cycle; gnt_valid stays 1.
// 5. Enable: enable=0 with req=16'h00FF.
//    -> gnt_valid stays 0.
//    Deassert enable while in GRANT.
//    -> the grant is held until the handshake, then IDLE with outputs zero.
// 6. Reset mid-op: rst=1 while gnt_valid=1, gnt_idx=7.
//    -> next cycle all outputs are 0.
//    Then req=16'h8001 -> gnt_idx=0 (ptr reset to 0).

Source files
------------

// File: rtl/rr_encoder_arbiter_if.sv
// ---------------------------------------------------------------------------
// rr_encoder_arbiter_if
//   Bundles the request side and the grant handshake of the round-robin
//   arbiter. clk and rst are not part of the bundle.
//
//   Signals:
//     enable      arbitration enable (driven by master)
//     req[N]      request vector, bit i = requester i (driven by master)
//     gnt_ready   downstream accepts the current grant (driven by master)
//     gnt_valid   grant outputs are valid (driven by slave)
//     gnt_onehot  one-hot grant, zero when not valid (driven by slave)
//     gnt_idx[W]  binary index of the granted bit, zero when not valid
//     busy        arbiter holds a grant (equals gnt_valid)
//
//   Handshake: a grant is offered while gnt_valid=1 and is transferred on a
//   rising edge where gnt_valid=1 and gnt_ready=1. While gnt_valid=1 and
//   gnt_ready=0 the grant outputs stay stable; a grant is never withdrawn
//   except by reset.
// ---------------------------------------------------------------------------
interface rr_encoder_arbiter_if #(
  parameter int N = 16
) ();
  localparam int W = $clog2(N);

  logic         enable;
  logic [N-1:0] req;
  logic         gnt_ready;
  logic         gnt_valid;
  logic [N-1:0] gnt_onehot;
  logic [W-1:0] gnt_idx;
  logic         busy;

  // master: the requester/consumer side that drives requests and ready
  modport master (
    output enable, req, gnt_ready,
    input  gnt_valid, gnt_onehot, gnt_idx, busy
  );

  // slave: the arbiter itself
  modport slave (
    input  enable, req, gnt_ready,
    output gnt_valid, gnt_onehot, gnt_idx, busy
  );
endinterface

// File: rtl/rr_encoder_arbiter.sv
// ---------------------------------------------------------------------------
// rr_encoder_arbiter
//   Round-robin arbiter sharing one downstream consumer among N requesters.
//   The winner is presented as a one-hot grant plus its binary index and is
//   held under a valid/ready handshake. All outputs are registered; a
//   request sampled while idle is granted on the following cycle.
//
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset, overrides everything
//     bus   rr_encoder_arbiter_if.slave (enable, req, gnt_ready in;
//           gnt_valid, gnt_onehot, gnt_idx, busy out)
//
//   ptr_q is the highest-priority index; the search runs ptr, ptr+1, ...
//   wrapping mod N. ptr_q only moves on a handshake (to granted index + 1),
//   so the requester granted last becomes lowest priority next.
// ---------------------------------------------------------------------------
module rr_encoder_arbiter #(
  parameter int N = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_encoder_arbiter_if.slave  bus
);
  localparam int W = $clog2(N);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t       state_q, state_d;
  logic [W-1:0] ptr_q, ptr_d;
  logic [W-1:0] idx_q, idx_d;
  logic [N-1:0] onehot_q, onehot_d;

  logic [W-1:0] base;   // priority start used for this cycle's search
  logic [W-1:0] win;    // winning index for the current req
  logic [W-1:0] cand;
  logic         arb_ok;

  // In GRANT the only time a new winner is used is on a handshake, and then
  // the search must already start from the post-handshake pointer.
  always_comb begin
    base = ptr_q;
    if (state_q == GRANT) begin
      base = idx_q + W'(1);
    end
  end

  // Walk offsets from far to near so the nearest set bit to base wins.
  // W-bit addition wraps naturally because N is a power of two.
  always_comb begin
    win  = '0;
    cand = '0;
    for (int i = N - 1; i >= 0; i--) begin
      cand = base + W'(i);
      if (bus.req[cand]) begin
        win = cand;
      end
    end
  end

  assign arb_ok = bus.enable && (|bus.req);

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    idx_d    = idx_q;
    onehot_d = onehot_q;
    case (state_q)
      IDLE: begin
        if (arb_ok) begin
          state_d  = GRANT;
          idx_d    = win;
          onehot_d = {{(N-1){1'b0}}, 1'b1} << win;
        end
      end
      GRANT: begin
        // Without ready everything holds, whatever req/enable do.
        if (bus.gnt_ready) begin
          ptr_d = idx_q + W'(1);
          if (arb_ok) begin
            idx_d    = win;
            onehot_d = {{(N-1){1'b0}}, 1'b1} << win;
          end else begin
            state_d  = IDLE;
            idx_d    = '0;
            onehot_d = '0;
          end
        end
      end
      default: begin
        state_d  = IDLE;
        idx_d    = '0;
        onehot_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      idx_q    <= '0;
      onehot_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      idx_q    <= idx_d;
      onehot_q <= onehot_d;
    end
  end

  assign bus.gnt_valid  = (state_q == GRANT);
  assign bus.busy       = (state_q == GRANT);
  assign bus.gnt_idx    = idx_q;
  assign bus.gnt_onehot = onehot_q;
endmodule

// File: tb/tb_rr_encoder_arbiter.sv
module tb_rr_encoder_arbiter;
  localparam int N = 16;
  localparam int W = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rr_encoder_arbiter_if #(.N(N)) bus ();

  rr_encoder_arbiter #(.N(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // ---------------- reference model ----------------
  // Tracks "a grant is pending", the priority pointer and the granted index
  // as plain integers; the winner is found by scanning (ptr+k) mod N.
  bit m_pend = 1'b0;
  int m_ptr  = 0;
  int m_idx  = 0;

  function automatic int pick(logic [N-1:0] r, int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  task automatic model_edge(input bit r, input bit e, input logic [N-1:0] q,
                            input bit rdy);
    if (r) begin
      m_pend = 1'b0; m_ptr = 0; m_idx = 0;
    end else if (!m_pend) begin
      if (e && q != 0) begin
        m_idx  = pick(q, m_ptr);
        m_pend = 1'b1;
      end
    end else if (rdy) begin
      m_ptr = (m_idx + 1) % N;
      if (e && q != 0) begin
        m_idx = pick(q, m_ptr);
      end else begin
        m_pend = 1'b0;
        m_idx  = 0;
      end
    end
  endtask

  // ---------------- scoreboard helper ----------------
  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // Drives inputs away from the edge, advances one clock, updates the model
  // and compares all outputs 1 time unit after the edge.
  task automatic step(input bit r, input bit e, input logic [N-1:0] q,
                      input bit rdy);
    logic [N-1:0] exp_oh;
    logic [N-1:0] one;
    rst           = r;
    bus.enable    = e;
    bus.req       = q;
    bus.gnt_ready = rdy;
    @(posedge clk);
    model_edge(r, e, q, rdy);
    #1;
    one    = {{(N-1){1'b0}}, 1'b1};
    exp_oh = m_pend ? (one << m_idx) : '0;
    check("model", {10'd0, bus.gnt_valid, bus.busy, bus.gnt_idx, bus.gnt_onehot},
          {10'd0, m_pend, m_pend, W'(m_pend ? m_idx : 0), exp_oh});
    if (bus.gnt_valid) begin
      check("onehot_inv", 32'(bus.gnt_onehot), 32'(one << bus.gnt_idx));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit           r;
    bit           e;
    logic [N-1:0] q;
    bit           rdy;
    bit           x_valid;
    logic [W-1:0] x_idx;
    logic [N-1:0] x_oh;
  } vec_t;

  vec_t vt[$];

  task automatic tbl_check(input int i);
    check($sformatf("tbl%0d_valid", i), 32'(bus.gnt_valid), 32'(vt[i].x_valid));
    check($sformatf("tbl%0d_idx", i),   32'(bus.gnt_idx),   32'(vt[i].x_idx));
    check($sformatf("tbl%0d_oh", i),    32'(bus.gnt_onehot), 32'(vt[i].x_oh));
  endtask

  logic [N-1:0] rq;

  initial begin
    rst = 1'b1; bus.enable = 1'b0; bus.req = '0; bus.gnt_ready = 1'b0;

    // reset, single request, stall with changing req, reset mid-grant, enable=0
    vt.push_back('{1, 0, 16'h0000, 0, 0, 4'd0,  16'h0000});
    vt.push_back('{0, 1, 16'h0002, 0, 1, 4'd1,  16'h0002});
    vt.push_back('{0, 1, 16'h0010, 1, 1, 4'd4,  16'h0010});
    vt.push_back('{0, 1, 16'h8000, 0, 1, 4'd4,  16'h0010});
    vt.push_back('{0, 1, 16'h8000, 0, 1, 4'd4,  16'h0010});
    vt.push_back('{0, 0, 16'h8000, 0, 1, 4'd4,  16'h0010});
    vt.push_back('{0, 1, 16'h8000, 0, 1, 4'd4,  16'h0010});
    vt.push_back('{0, 1, 16'h8000, 1, 1, 4'd15, 16'h8000});
    vt.push_back('{0, 1, 16'h0000, 1, 0, 4'd0,  16'h0000});
    vt.push_back('{0, 1, 16'h0080, 0, 1, 4'd7,  16'h0080});
    vt.push_back('{1, 1, 16'h0080, 0, 0, 4'd0,  16'h0000});
    vt.push_back('{0, 1, 16'h8001, 0, 1, 4'd0,  16'h0001});
    vt.push_back('{0, 0, 16'h0000, 1, 0, 4'd0,  16'h0000});
    vt.push_back('{0, 0, 16'h00FF, 0, 0, 4'd0,  16'h0000});
    vt.push_back('{0, 0, 16'h00FF, 1, 0, 4'd0,  16'h0000});

    for (int i = 0; i < vt.size(); i++) begin
      step(vt[i].r, vt[i].e, vt[i].q, vt[i].rdy);
      tbl_check(i);
    end

    // round robin over all requesters, ready held high: 0,1,..,15,0
    step(1, 0, '0, 0);
    for (int k = 0; k <= N; k++) begin
      step(0, 1, 16'hFFFF, 1);
      check($sformatf("rr_idx%0d", k), 32'(bus.gnt_idx), 32'(k % N));
      check($sformatf("rr_valid%0d", k), 32'(bus.gnt_valid), 32'd1);
    end

    // sole requester keeps winning back-to-back
    for (int k = 0; k < 4; k++) begin
      step(0, 1, 16'h0001, 1);
      check($sformatf("sole_idx%0d", k), 32'(bus.gnt_idx), 32'd0);
      check($sformatf("sole_valid%0d", k), 32'(bus.gnt_valid), 32'd1);
    end

    // enable drops during GRANT: grant held until handshake, then idle
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 16'h00FF, 0);
      check($sformatf("endrop_hold%0d", k), 32'(bus.gnt_valid), 32'd1);
      check($sformatf("endrop_oh%0d", k), 32'(bus.gnt_onehot), 32'h0001);
    end
    step(0, 0, 16'h00FF, 1);
    check("endrop_idle_valid", 32'(bus.gnt_valid), 32'd0);
    check("endrop_idle_oh", 32'(bus.gnt_onehot), 32'd0);
    check("endrop_idle_busy", 32'(bus.busy), 32'd0);

    // randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      case ($urandom_range(0, 3))
        0:       rq = N'($urandom);
        1:       rq = {{(N-1){1'b0}}, 1'b1} << $urandom_range(0, N - 1);
        2:       rq = N'($urandom) & N'($urandom) & N'($urandom);
        default: rq = '0;
      endcase
      step($urandom_range(0, 59) == 0, $urandom_range(0, 9) != 0, rq,
           $urandom_range(0, 2) != 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
